score_display_mux: RTL and testbench
====================================

# score_display_mux

- Downstream consumer of both two-digit BCD scoreboards (left player, right player); drives the board's 4-digit multiplexed seven-segment display.
- Scans one digit per refresh slot and decodes BCD to active-low segments.
- Snapshots all four score digits once per frame so a digit never changes mid-scan.
- Supports leading-zero blanking, an invalid-digit dash, and a whole-display blink used to flag the winner.

## Interface
Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot; legal range ≥2.
- BLINK_FRAMES, 62: full frames (4 slots each) per blink half-period; legal range ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- leftscoreLeft  in  4  left player tens BCD.
- leftscoreRight  in  4  left player units BCD.
- rightscoreLeft  in  4  right player tens BCD.
- rightscoreRight  in  4  right player units BCD.
- blank_lz  in  1  when 1, blank a tens digit equal to 0.
- blink  in  1  when 1, whole display flashes.
- an  out  4  anode enables, active-low; an[0] is the rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- Slot counter cnt runs 0..REFRESH_DIV-1 and wraps. Digit index idx advances 0→1→2→3→0 on the cnt wrap.
- Frame wrap condition: idx==3 and cnt==REFRESH_DIV-1.
- Digit mapping:
  - idx0 = rightscoreRight
  - idx1 = rightscoreLeft
  - idx2 = leftscoreRight
  - idx3 = leftscoreLeft
- Snapshot:
  - Four 4-bit shadow registers load all inputs together in the cycle where idx==0 and cnt==0.
  - In that load cycle, decode uses the live inputs (bypass), so the new frame is consistent from its first cycle.
- Decode table (seg):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - values 10–15 = 0111111 (dash, g only)
- Anodes: the active digit's an bit is 0; all other bits are 1.
- Leading-zero blanking: with blank_lz=1, a shadowed tens digit (idx1 or idx3) equal to 0 forces an=1111 for that slot. seg still shows the decode.
- dp is 0 only during idx2, as a separator between players; otherwise 1.
- Blink:
  - Frame counter fc counts frame wraps; at BLINK_FRAMES-1 it clears and toggles phase.
  - While phase==off and blink==1, an=1111.
  - When blink==0, fc is cleared and phase is forced to on every cycle. Raising blink therefore always starts with a full on half-period.
  - Blanking and blink never affect the scan counters.

## Timing
- Outputs are registered. an, seg and dp at cycle t+1 reflect idx, cnt, shadow and phase at cycle t.
- Reset values: cnt=0, idx=0, shadow=0, fc=0, phase=on, an=1111, seg=1111111, dp=1.
- The first cycle after reset deasserts loads the shadow registers. Outputs show digit 0 from the next edge.
- Input changes are visible at the first slot of the next frame, i.e. within 4·REFRESH_DIV+1 cycles. Mid-frame changes are ignored until then.
- Reset asserted mid-frame returns to the reset values on the next edge; no partial frame completes.
- blink and blank_lz are sampled combinationally into the output register, so they take effect with 1-cycle latency.

## Test plan
All tests use REFRESH_DIV=4, BLINK_FRAMES=2.

- **Reset and scan order.** Reset, then inputs L=4,2 and R=1,7 (leftscoreLeft, leftscoreRight, rightscoreLeft, rightscoreRight).
  - Required: an sequence 1110,1101,1011,0111 with 4 cycles each.
  - Required: seg 1111000 (7), 1111001 (1), 0100100 (2), 0011001 (4).
  - Required: dp=0 only while an=1011.
- **Snapshot.** Change rightscoreRight from 7 to 3 while idx==2.
  - Required: digit 0 shows 7 until the next frame's idx0 slot, then shows 0110000.
- **Leading-zero blanking.** blank_lz=1 with leftscoreLeft=0 and rightscoreLeft=5.
  - Required: an=1111 during the idx3 slot; idx1 shows 0010010 with an=1101.
- **Invalid digit.** leftscoreRight=12.
  - Required: seg=0111111 during idx2.
- **Blink.** blink=1.
  - Required: display on for 2 frames (32 cycles), an=1111 for the next 32 cycles, then repeating.
  - Required: dropping blink restores display within 1 cycle.
- **Reset mid-frame.** Assert reset at idx2, cnt==1.
  - Required: next edge an=1111, seg=1111111, dp=1.
  - Required: after release, scanning restarts at idx0.

Source files
------------

// File: rtl/score_display_mux.sv
// Four-digit multiplexed seven-segment driver for the two-player scoreboard.
// It snapshots the scores once per frame and supports leading-zero blanking, a dash for invalid BCD, and a whole-display blink.
module score_display_mux #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 62
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] leftscoreLeft,
  input  logic [3:0] leftscoreRight,
  input  logic [3:0] rightscoreLeft,
  input  logic [3:0] rightscoreRight,
  input  logic       blank_lz,
  input  logic       blink,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  // state  | meaning
  // PH_ON  | display visible (blink on half-period, or blink idle)
  // PH_OFF | blink off half-period, all anodes disabled
  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } phase_t;

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int FC_W  = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0][3:0]  sh_q, sh_d;
  logic [FC_W-1:0]  fc_q, fc_d;
  phase_t           phase_q, phase_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;

  logic       slot_wrap;
  logic       frame_wrap;
  logic       load;
  logic       fc_last;
  logic [3:0] digit;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      sh_q    <= '0;
      fc_q    <= '0;
      phase_q <= PH_ON;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      fc_q    <= fc_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  // Scan counters, frame snapshot and blink frame counter.
  always_comb begin
    slot_wrap  = (cnt_q == CNT_LAST);
    frame_wrap = slot_wrap && (idx_q == 2'd3);
    load       = (idx_q == 2'd0) && (cnt_q == '0);
    fc_last    = (fc_q == FC_LAST);

    cnt_d = slot_wrap ? '0 : cnt_q + CNT_W'(1);
    idx_d = slot_wrap ? idx_q + 2'd1 : idx_q;

    sh_d = sh_q;
    if (load) begin
      sh_d = {leftscoreLeft, leftscoreRight, rightscoreLeft, rightscoreRight};
    end

    fc_d = fc_q;
    if (!blink) begin
      fc_d = '0;
    end else if (frame_wrap) begin
      fc_d = fc_last ? '0 : fc_q + FC_W'(1);
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (!blink) begin
      phase_d = PH_ON;
    end else if (frame_wrap && fc_last) begin
      phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
    end
  end

  // The load cycle bypasses the shadow so the frame's first slot already shows the new value.
  always_comb begin
    digit = load ? rightscoreRight : sh_q[idx_q];

    case (digit)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b0111111;
    endcase

    an_d = ~(4'b0001 << idx_q);
    if (blank_lz && idx_q[0] && (digit == 4'd0)) begin
      an_d = 4'b1111;
    end
    if (blink && (phase_q == PH_OFF)) begin
      an_d = 4'b1111;
    end

    dp_d = (idx_q != 2'd2);
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_score_display_mux.sv
// Bench for score_display_mux with REFRESH_DIV=4 and BLINK_FRAMES=2.
// Per-frame vectors feed a scoreboard queue that is compared against the outputs on every falling edge.
module tb_score_display_mux;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ll = 4'd0, lr = 4'd0, rl = 4'd0, rr = 4'd0;
  logic       blank_lz = 1'b0;
  logic       blink = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  score_display_mux #(.REFRESH_DIV(4), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset(reset),
    .leftscoreLeft(ll), .leftscoreRight(lr),
    .rightscoreLeft(rl), .rightscoreRight(rr),
    .blank_lz(blank_lz), .blink(blink),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ll, lr, rl, rr;
    logic        blz;
    logic [15:0] an_exp;   // slot k in [4k+3:4k]
    logic [27:0] seg_exp;  // slot k in [7k+6:7k]
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  vec_t  vecs [6];
  exp_t  exp_q [$];
  string name_q [$];
  int    pass_cnt = 0;
  int    total_cnt = 0;

  task automatic push_exp(input exp_t e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic check_cycle();
    exp_t  e;
    string nm;
    @(negedge clk);
    total_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard_underflow: got an=%b seg=%b dp=%b, required an entry", an, seg, dp);
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if ({an, seg, dp} === e) pass_cnt++;
      else $display("FAIL %s: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                    nm, an, seg, dp, e.an, e.seg, e.dp);
    end
  endtask

  task automatic drive_inputs(input vec_t v);
    ll = v.ll; lr = v.lr; rl = v.rl; rr = v.rr;
    blank_lz = v.blz;
  endtask

  // off: expect blanked anodes up to and including cycle drop_at (whole frame if drop_at<0)
  task automatic push_frame(input vec_t v, input bit off, input int drop_at,
                            input int n, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      int s;
      s = i / 4;
      e.an  = v.an_exp[s*4 +: 4];
      e.seg = v.seg_exp[s*7 +: 7];
      e.dp  = (s == 2) ? 1'b0 : 1'b1;
      if (off && (drop_at < 0 || i <= drop_at)) e.an = 4'b1111;
      push_exp(e, $sformatf("%s_c%0d", tag, i));
    end
  endtask

  task automatic run_frame(input vec_t v, input bit off, input int drop_at,
                           input int n, input string tag);
    drive_inputs(v);
    push_frame(v, off, drop_at, n, tag);
    for (int i = 0; i < n; i++) begin
      check_cycle();
      if (i == drop_at) blink = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    exp_t e;
    e.an = 4'b1111; e.seg = 7'b1111111; e.dp = 1'b1;
    push_exp(e, tag);
    check_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required the bench to finish");
    $fatal(1);
  end

  initial begin
    // ll lr rl rr blz, an slot3..0, seg slot3..0
    vecs[0] = '{4'd4, 4'd2, 4'd1, 4'd7, 1'b0,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b0011001, 7'b0100100, 7'b1111001, 7'b1111000}};
    vecs[1] = '{4'd0, 4'd12, 4'd5, 4'd3, 1'b1,
                {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1000000, 7'b0111111, 7'b0010010, 7'b0110000}};
    vecs[2] = '{4'd0, 4'd8, 4'd0, 4'd9, 1'b0,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1000000, 7'b0000000, 7'b1000000, 7'b0010000}};
    vecs[3] = '{4'd9, 4'd6, 4'd0, 4'd5, 1'b1,
                {4'b0111, 4'b1011, 4'b1111, 4'b1110},
                {7'b0010000, 7'b0000010, 7'b1000000, 7'b0010010}};
    vecs[4] = '{4'd15, 4'd10, 4'd1, 4'd0, 1'b1,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b0111111, 7'b0111111, 7'b1111001, 7'b1000000}};
    vecs[5] = '{4'd9, 4'd2, 4'd1, 4'd3, 1'b0,
                {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b0010000, 7'b0100100, 7'b1111001, 7'b0110000}};

    check_reset_outputs("reset_hold0");
    check_reset_outputs("reset_hold1");

    // Released on a falling edge; the next rising edge is the load cycle.
    reset = 1'b0;
    run_frame(vecs[0], 1'b0, -1, 16, "scan_order");
    for (int k = 1; k < 5; k++) run_frame(vecs[k], 1'b0, -1, 16, $sformatf("table%0d", k));

    // Snapshot: mid-frame changes must not show until the next frame.
    drive_inputs(vecs[0]);
    push_frame(vecs[0], 1'b0, -1, 16, "snap_hold");
    for (int i = 0; i < 16; i++) begin
      check_cycle();
      if (i == 8) begin
        rr = 4'd3;
        ll = 4'd9;
      end
    end
    run_frame(vecs[5], 1'b0, -1, 16, "snap_next");

    // Blink: two frames on, two off, repeating; dropping it restores the display in one cycle.
    blink = 1'b1;
    run_frame(vecs[0], 1'b0, -1, 16, "blink_on_a");
    run_frame(vecs[0], 1'b0, -1, 16, "blink_on_b");
    run_frame(vecs[0], 1'b1, -1, 16, "blink_off_a");
    run_frame(vecs[0], 1'b1, -1, 16, "blink_off_b");
    run_frame(vecs[0], 1'b0, -1, 16, "blink_on_c");
    run_frame(vecs[0], 1'b0, -1, 16, "blink_on_d");
    run_frame(vecs[0], 1'b1, 5, 16, "blink_drop");
    run_frame(vecs[0], 1'b0, -1, 16, "blink_idle");
    blink = 1'b1;
    run_frame(vecs[0], 1'b0, -1, 16, "blink_restart_a");
    run_frame(vecs[0], 1'b0, -1, 16, "blink_restart_b");
    run_frame(vecs[0], 1'b1, -1, 16, "blink_restart_off");
    blink = 1'b0;
    run_frame(vecs[0], 1'b0, -1, 16, "blink_cleared");

    // Reset mid-frame: raised while the DUT is at idx2, cnt1.
    run_frame(vecs[2], 1'b0, -1, 9, "pre_reset");
    reset = 1'b1;
    check_reset_outputs("mid_reset0");
    check_reset_outputs("mid_reset1");
    reset = 1'b0;
    run_frame(vecs[0], 1'b0, -1, 16, "post_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
